// File: rtl/noc_pkg.sv
// Shared NoC op codes and sequencer state encoding; routers and traffic sources
// decode the same op constants.
package noc_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_NOP          = 4'd0;
  localparam logic [OP_W-1:0] OP_PHASE0       = 4'd1;
  localparam logic [OP_W-1:0] OP_PHASE1       = 4'd2;
  localparam logic [OP_W-1:0] OP_LOAD_STAGING = 4'd3;
  localparam logic [OP_W-1:0] OP_LOAD_RT      = 4'd4;
  localparam logic [OP_W-1:0] OP_INIT         = 4'd5;
  localparam logic [OP_W-1:0] OP_FILL         = 4'd6;
  localparam logic [OP_W-1:0] OP_DEQUEUE      = 4'd7;
  localparam logic [OP_W-1:0] OP_PREDEQUE     = 4'd8;

  typedef enum logic [3:0] {
    S_IDLE,
    S_TINIT,
    S_TFILL,
    S_TPREDEQ,
    S_RINIT,
    S_RLOADRT,
    S_STAGE,
    S_PH0,
    S_PH1,
    S_DONE
  } seq_state_e;

endpackage

// File: rtl/noc_sequencer.sv
// NoC bring-up and simulation-loop sequencer: broadcasts router/traffic ops and
// drives the config-memory index counters from one registered state machine.
module noc_sequencer
  import noc_pkg::*;
#(
  parameter int NUM_ROUTERS = 16,
  parameter int ROUTER_W    = 4,
  parameter int TRAFFIC_W   = 10,
  parameter int CYCLE_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CYCLE_W-1:0]   max_cycle,
  input  logic [TRAFFIC_W-1:0] fill_count,
  input  logic                 all_done,
  output logic [OP_W-1:0]      router_op,
  output logic [OP_W-1:0]      traffic_op,
  output logic [ROUTER_W-1:0]  rt_dst,
  output logic [TRAFFIC_W-1:0] fill_idx,
  output logic [CYCLE_W-1:0]   in_cycle,
  output logic                 busy,
  output logic                 finished,
  output logic                 timeout
);

  localparam logic [ROUTER_W-1:0] RT_LAST = ROUTER_W'(NUM_ROUTERS - 1);

  seq_state_e           state_q, state_d;
  logic [TRAFFIC_W-1:0] fill_q, fill_d;
  logic [ROUTER_W-1:0]  rt_q, rt_d;
  logic [CYCLE_W-1:0]   cyc_q, cyc_d;
  logic                 to_q, to_d;
  logic                 last_cycle;

  function automatic logic [CYCLE_W-1:0] sat_inc(input logic [CYCLE_W-1:0] v);
    return (&v) ? v : v + CYCLE_W'(1);
  endfunction

  // Widened so that max_cycle == all-ones is still reachable without wrap.
  assign last_cycle = ({1'b0, cyc_q} + (CYCLE_W+1)'(1)) == {1'b0, max_cycle};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      fill_q  <= '0;
      rt_q    <= '0;
      cyc_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      rt_q    <= rt_d;
      cyc_q   <= cyc_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fill_d     = fill_q;
    rt_d       = rt_q;
    cyc_d      = cyc_q;
    to_d       = to_q;
    router_op  = OP_NOP;
    traffic_op = OP_NOP;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_TINIT;
          fill_d  = '0;
          rt_d    = '0;
          cyc_d   = '0;
          to_d    = 1'b0;
        end
      end
      S_TINIT: begin
        traffic_op = OP_INIT;
        state_d    = (fill_count == '0) ? S_TPREDEQ : S_TFILL;
      end
      S_TFILL: begin
        traffic_op = OP_FILL;
        if (fill_q == fill_count - TRAFFIC_W'(1)) state_d = S_TPREDEQ;
        else                                      fill_d  = fill_q + TRAFFIC_W'(1);
      end
      S_TPREDEQ: begin
        traffic_op = OP_PREDEQUE;
        state_d    = S_RINIT;
      end
      S_RINIT: begin
        router_op = OP_INIT;
        state_d   = S_RLOADRT;
      end
      S_RLOADRT: begin
        router_op = OP_LOAD_RT;
        if (rt_q == RT_LAST) begin
          if (max_cycle == '0) begin
            state_d = S_DONE;
            to_d    = !all_done;
          end else begin
            state_d = S_STAGE;
          end
        end else begin
          rt_d = rt_q + ROUTER_W'(1);
        end
      end
      S_STAGE: begin
        router_op  = OP_LOAD_STAGING;
        traffic_op = OP_DEQUEUE;
        state_d    = S_PH0;
      end
      S_PH0: begin
        router_op = OP_PHASE0;
        state_d   = S_PH1;
      end
      S_PH1: begin
        router_op = OP_PHASE1;
        cyc_d     = sat_inc(cyc_q);
        // all_done takes priority over the cycle limit, so timeout stays low.
        if (all_done || last_cycle) begin
          state_d = S_DONE;
          to_d    = !all_done;
        end else begin
          state_d = S_STAGE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign fill_idx = (state_q == S_TFILL)   ? fill_q : '0;
  assign rt_dst   = (state_q == S_RLOADRT) ? rt_q   : '0;
  assign in_cycle = cyc_q;
  assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
  assign finished = (state_q == S_DONE);
  assign timeout  = to_q;

endmodule

// File: tb/tb_noc_sequencer.sv
// Randomized bench for noc_sequencer: a per-cycle expected op schedule is built
// from the bring-up/round rules and compared against the DUT every cycle.
module tb_noc_sequencer;
  import noc_pkg::*;

  localparam int N  = 4;
  localparam int RW = 2;
  localparam int TW = 10;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] max_cycle;
  logic [TW-1:0] fill_count;
  logic          all_done;
  logic [OP_W-1:0] router_op, traffic_op;
  logic [RW-1:0] rt_dst;
  logic [TW-1:0] fill_idx;
  logic [CW-1:0] in_cycle;
  logic          busy, finished, timeout;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [3:0]  rop;
    logic [3:0]  top;
    logic [9:0]  fidx;
    logic [1:0]  rdst;
    logic [15:0] inc;
    logic        ad;
  } step_t;

  step_t exp_q[$];

  noc_sequencer #(.NUM_ROUTERS(N), .ROUTER_W(RW), .TRAFFIC_W(TW), .CYCLE_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .max_cycle(max_cycle),
    .fill_count(fill_count), .all_done(all_done), .router_op(router_op),
    .traffic_op(traffic_op), .rt_dst(rt_dst), .fill_idx(fill_idx),
    .in_cycle(in_cycle), .busy(busy), .finished(finished), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic step_t mk(input logic [3:0] r, input logic [3:0] t, input int fi,
                               input int rd, input int ic, input logic ad);
    step_t s;
    s.rop = r; s.top = t; s.fidx = 10'(fi); s.rdst = 2'(rd); s.inc = 16'(ic); s.ad = ad;
    return s;
  endfunction

  // Expected busy-cycle schedule; all_done is random outside PH1 and only
  // asserted in the PH1 of round dr (dr==0 or dr>M: never).
  task automatic build(input int F, input int M, input int dr,
                       output int rounds, output bit to);
    exp_q.delete();
    exp_q.push_back(mk(OP_NOP, OP_INIT, 0, 0, 0, 1'($urandom_range(0, 1))));
    for (int i = 0; i < F; i++)
      exp_q.push_back(mk(OP_NOP, OP_FILL, i, 0, 0, 1'($urandom_range(0, 1))));
    exp_q.push_back(mk(OP_NOP, OP_PREDEQUE, 0, 0, 0, 1'($urandom_range(0, 1))));
    exp_q.push_back(mk(OP_INIT, OP_NOP, 0, 0, 0, 1'($urandom_range(0, 1))));
    for (int i = 0; i < N; i++)
      exp_q.push_back(mk(OP_LOAD_RT, OP_NOP, 0, i, 0, 1'($urandom_range(0, 1))));
    rounds = 0;
    to = 1'b1;
    if (M == 0) to = !exp_q[exp_q.size()-1].ad;
    for (int r = 1; r <= M; r++) begin
      rounds = r;
      exp_q.push_back(mk(OP_LOAD_STAGING, OP_DEQUEUE, 0, 0, r-1, 1'($urandom_range(0, 1))));
      exp_q.push_back(mk(OP_PHASE0, OP_NOP, 0, 0, r-1, 1'($urandom_range(0, 1))));
      exp_q.push_back(mk(OP_PHASE1, OP_NOP, 0, 0, r-1, r == dr));
      if (r == dr) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    all_done = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int F, input int M, input int dr, input bit hold);
    int rounds;
    bit to;
    build(F, M, dr, rounds, to);
    fill_count = TW'(F);
    max_cycle  = CW'(M);
    all_done   = 1'b0;
    start      = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    chk("busy_len", exp_q.size(), 1 + F + 1 + 1 + N + 3 * rounds);
    foreach (exp_q[i]) begin
      chk("busy", busy, 1'b1);
      chk("finished_run", finished, 1'b0);
      chk("router_op", router_op, exp_q[i].rop);
      chk("traffic_op", traffic_op, exp_q[i].top);
      chk("fill_idx", fill_idx, exp_q[i].fidx);
      chk("rt_dst", rt_dst, exp_q[i].rdst);
      chk("in_cycle_run", in_cycle, exp_q[i].inc);
      all_done = exp_q[i].ad;
      @(posedge clk);
      #1;
    end
    all_done = 1'b0;
    chk("done_busy", busy, 1'b0);
    chk("done_finished", finished, 1'b1);
    chk("done_timeout", timeout, to);
    chk("done_in_cycle", in_cycle, rounds);
    chk("done_rop", router_op, OP_NOP);
    chk("done_top", traffic_op, OP_NOP);
    @(posedge clk);
    #1;
    if (hold) begin
      start = 1'b0;
      chk("restart_top", traffic_op, OP_INIT);
      chk("restart_in_cycle", in_cycle, 0);
      chk("restart_timeout", timeout, 1'b0);
      chk("restart_busy", busy, 1'b1);
      do_reset();
    end else begin
      chk("hold_finished", finished, 1'b1);
      chk("hold_in_cycle", in_cycle, rounds);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    all_done = 1'b0;
    max_cycle = '0;
    fill_count = '0;
    #1;
    chk("rst_rop", router_op, OP_NOP);
    chk("rst_top", traffic_op, OP_NOP);
    chk("rst_busy", busy, 1'b0);
    chk("rst_finished", finished, 1'b0);
    chk("rst_in_cycle", in_cycle, 0);
    chk("rst_timeout", timeout, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run(3, 2, 0, 1'b0);     // nominal
    run(0, 0, 0, 1'b0);     // no fill, no cycles
    run(2, 100, 1, 1'b0);   // early finish in first PH1
    run(1, 1, 1, 1'b0);     // simultaneous terminate
    run(2, 3, 0, 1'b1);     // start held high through run

    // Asynchronous reset in the middle of the routing-table load.
    fill_count = 10'd2;
    max_cycle  = 16'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    chk("pre_rst_rop", router_op, OP_LOAD_RT);
    rst_n = 1'b0;
    #1;
    chk("async_rop", router_op, OP_NOP);
    chk("async_top", traffic_op, OP_NOP);
    chk("async_busy", busy, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_finished", finished, 1'b0);
    chk("post_rst_in_cycle", in_cycle, 0);

    for (int k = 0; k < 12; k++) begin
      int f, m, d;
      f = $urandom_range(0, 6);
      m = $urandom_range(0, 5);
      d = $urandom_range(0, m + 1);
      run(f, m, d, k[0]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
